// File: rtl/pll_mdrp_master.sv
// pll_mdrp_master: MDRP initiator for the Gowin PLLA, optional relock sequence under `PLL_MDRP_RESET_SEQ_EN.
// Latency from accept: write 3, read 3+RD_LAT, reserved 2, commit RST_CYCLES + lock wait + 1.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle pulse that cannot be stalled.
module pll_mdrp_master #(
   parameter int RD_LAT       = 2,
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy,
   output logic [1:0] md_opc,
   output logic       md_ainc,
   output logic [7:0] md_wdi,
   input  logic [7:0] md_rdo,
   input  logic       pll_lock,
   output logic       pll_reset
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WR, S_RD, S_RD_WAIT, S_RST, S_LOCK_WAIT, S_RESP
   } state_t;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;

   localparam logic [1:0] MD_NOP   = 2'b00;
   localparam logic [1:0] MD_WRITE = 2'b01;
   localparam logic [1:0] MD_READ  = 2'b10;
   localparam logic [1:0] MD_ADDR  = 2'b11;

   state_t     state, next_state;
   logic       accept;
   logic [1:0] op_q;
   logic [7:0] wdata_q;
   logic [2:0] rd_cnt;
   logic       lock_fail;

   logic [1:0] md_opc_nxt;
   logic [7:0] md_wdi_nxt;
   logic [7:0] rsp_rdata_nxt;
   logic       rsp_valid_nxt;
   logic       rsp_err_nxt;

`ifdef PLL_MDRP_RESET_SEQ_EN
   logic [15:0] tmr_cnt;
   logic        lock_s1, lock_s2;
   logic        pll_reset_nxt;
`endif

   assign accept    = cmd_valid & cmd_ready;
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign md_ainc   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_READ, OP_WRITE: next_state = S_ADDR;
`ifdef PLL_MDRP_RESET_SEQ_EN
                  OP_COMMIT:         next_state = S_RST;
`endif
                  default:           next_state = S_RESP;
               endcase
            end
         end
         S_ADDR:    next_state = (op_q == OP_WRITE) ? S_WR : S_RD;
`ifdef PLL_MDRP_RESET_SEQ_EN
         S_WR:      next_state = S_RST;
         S_RST:     next_state = (tmr_cnt == 16'd0) ? S_LOCK_WAIT : S_RST;
         S_LOCK_WAIT: begin
            if (lock_s2 || tmr_cnt == 16'(LOCK_TIMEOUT - 1)) next_state = S_RESP;
         end
`else
         S_WR:      next_state = S_RESP;
`endif
         S_RD:      next_state = S_RD_WAIT;
         S_RD_WAIT: next_state = (rd_cnt == 3'd0) ? S_RESP : S_RD_WAIT;
         // Entered straight from IDLE, RESP first spends one silent cycle so errors answer at cycle 2.
         S_RESP:    next_state = rsp_valid ? S_IDLE : S_RESP;
         default:   next_state = S_IDLE;
      endcase
   end

`ifdef PLL_MDRP_RESET_SEQ_EN
   assign lock_fail = (state == S_LOCK_WAIT) && !lock_s2;
`else
   assign lock_fail = 1'b0;
`endif

   always_comb begin
      md_opc_nxt    = MD_NOP;
      md_wdi_nxt    = md_wdi;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      rsp_valid_nxt = (next_state == S_RESP) && (state != S_IDLE);
`ifdef PLL_MDRP_RESET_SEQ_EN
      pll_reset_nxt = (next_state == S_RST);
`endif
      case (next_state)
         S_ADDR: begin
            md_opc_nxt = MD_ADDR;
            md_wdi_nxt = cmd_addr;
         end
         S_WR: begin
            md_opc_nxt = MD_WRITE;
            md_wdi_nxt = wdata_q;
         end
         S_RD:    md_opc_nxt = MD_READ;
         default: md_opc_nxt = MD_NOP;
      endcase
      if (state == S_RD_WAIT && rd_cnt == 3'd0) rsp_rdata_nxt = md_rdo;
      if (next_state == S_RESP && state != S_RESP) rsp_err_nxt = (state == S_IDLE) | lock_fail;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_opc    <= MD_NOP;
         md_wdi    <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
         rsp_err   <= 1'b0;
      end else begin
         md_opc    <= md_opc_nxt;
         md_wdi    <= md_wdi_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_READ;
         wdata_q <= 8'h00;
      end else if (accept) begin
         op_q    <= cmd_op;
         wdata_q <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                rd_cnt <= 3'd0;
      else if (state == S_RD)                    rd_cnt <= 3'(RD_LAT - 1);
      else if (state == S_RD_WAIT && rd_cnt != 0) rd_cnt <= rd_cnt - 3'd1;
   end

`ifdef PLL_MDRP_RESET_SEQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         lock_s1 <= pll_lock;
         lock_s2 <= lock_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pll_reset <= 1'b0;
      else        pll_reset <= pll_reset_nxt;
   end

   // One counter serves both the reset pulse (down) and the lock timeout (up).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt <= 16'd0;
      end else if (state != S_RST && next_state == S_RST) begin
         tmr_cnt <= 16'(RST_CYCLES - 1);
      end else if (state == S_RST) begin
         if (tmr_cnt != 16'd0) tmr_cnt <= tmr_cnt - 16'd1;
      end else if (state == S_LOCK_WAIT && next_state == S_LOCK_WAIT) begin
         tmr_cnt <= tmr_cnt + 16'd1;
      end else begin
         tmr_cnt <= 16'd0;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = pll_lock;
   assign pll_reset   = 1'b0;
`endif

endmodule

// File: tb/tb_pll_mdrp_master.sv
// Scoreboard bench for pll_mdrp_master with a behavioural MDRP slave and PLL lock model.
module tb_pll_mdrp_master;

   localparam int RD_LAT     = 2;
   localparam int RST_CYCLES = 16;
   localparam int LOCK_TMO   = 100;
`ifdef PLL_MDRP_RESET_SEQ_EN
   localparam int   LAT_WR     = 61;
   localparam int   LAT_COMMIT = 59;
   localparam logic ERR_COMMIT = 1'b0;
   localparam int   MID_WAIT   = 4;
`else
   localparam int   LAT_WR     = 3;
   localparam int   LAT_COMMIT = 2;
   localparam logic ERR_COMMIT = 1'b1;
   localparam int   MID_WAIT   = 2;
`endif

   logic       clk, rst_n;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err, busy;
   logic [7:0] rsp_rdata;
   logic [1:0] md_opc;
   logic       md_ainc;
   logic [7:0] md_wdi, md_rdo;
   logic       pll_lock, pll_reset;

   pll_mdrp_master #(.RD_LAT(RD_LAT), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .md_opc(md_opc), .md_ainc(md_ainc), .md_wdi(md_wdi), .md_rdo(md_rdo),
      .pll_lock(pll_lock), .pll_reset(pll_reset)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] mem [256];
   logic [7:0] m_addr = 8'h00;
   int         rd_due = -1;
   bit         lock_en = 1'b1;
   int         lock_cnt = 0;
   int         rst_run = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // MDRP slave: register file behind the address/write/read opcodes, read data only in its sample cycle.
   always @(negedge clk) begin
      case (md_opc)
         2'b11: m_addr = md_wdi;
         2'b01: mem[m_addr] = md_wdi;
         2'b10: rd_due = cyc + RD_LAT;
         default: ;
      endcase
      md_rdo = (cyc == rd_due) ? mem[m_addr] : 8'hEE;
   end

   // PLL model: lock drops in reset and returns 40 cycles after reset falls.
   always @(posedge clk) begin
      #1;
      if (!lock_en || pll_reset) begin
         lock_cnt = 0;
         pll_lock = 1'b0;
      end else begin
         if (lock_cnt < 40) lock_cnt++;
         pll_lock = (lock_cnt >= 40);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) rst_run = 0;
      else if (pll_reset) rst_run++;
      else if (rst_run != 0) begin
         chk("pll_reset_len", rst_run, RST_CYCLES);
         rst_run = 0;
      end
   end

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee, input int lat);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("issue_wait_ready", 32'(cmd_ready), 32'd1);
         return;
      end
      cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      e.rdata = er; e.err = ee; e.cyc = cyc + lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h34] = 8'hC3;
      md_rdo = 8'hEE; pll_lock = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_md_opc", md_opc, 2'b00);
      chk("rst_md_ainc", md_ainc, 1'b0);
      chk("rst_md_wdi", md_wdi, 8'h00);
      chk("rst_pll_reset", pll_reset, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 8'h00);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      issue(2'b01, 8'h12, 8'h5A, 8'h00, 1'b0, LAT_WR);
      @(negedge clk);
      chk("wr_c1_opc", md_opc, 2'b11);
      chk("wr_c1_wdi", md_wdi, 8'h12);
      chk("wr_c1_busy", busy, 1'b1);
      chk("wr_c1_ready", cmd_ready, 1'b0);
      @(negedge clk);
      chk("wr_c2_opc", md_opc, 2'b01);
      chk("wr_c2_wdi", md_wdi, 8'h5A);

      issue(2'b00, 8'h34, 8'h00, 8'hC3, 1'b0, 5);
      issue(2'b00, 8'h12, 8'h00, 8'h5A, 1'b0, 5);
      issue(2'b01, 8'h34, 8'h11, 8'h5A, 1'b0, LAT_WR);

      issue(2'b11, 8'hAB, 8'hCD, 8'h5A, 1'b1, 2);
      @(negedge clk);
      chk("rsv_c1_opc", md_opc, 2'b00);
      chk("rsv_c1_ready", cmd_ready, 1'b0);
      @(negedge clk);
      chk("rsv_c2_opc", md_opc, 2'b00);

      issue(2'b10, 8'h00, 8'h00, 8'h5A, ERR_COMMIT, LAT_COMMIT);
`ifdef PLL_MDRP_RESET_SEQ_EN
      lock_en = 1'b0;
      issue(2'b10, 8'h00, 8'h00, 8'h5A, 1'b1, 17 + LOCK_TMO);
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      lock_en = 1'b1;
`endif

      issue(2'b00, 8'h34, 8'h00, 8'h11, 1'b0, 5);
      issue(2'b00, 8'h12, 8'h00, 8'h5A, 1'b0, 5);

`ifdef PLL_MDRP_RESET_SEQ_EN
      issue(2'b10, 8'h00, 8'h00, 8'h5A, 1'b0, LAT_COMMIT);
`else
      issue(2'b00, 8'h34, 8'h00, 8'h11, 1'b0, 5);
`endif
      repeat (MID_WAIT) @(negedge clk);
      void'(exp_q.pop_back());
      rst_n = 1'b0;
      #1;
      chk("midrst_pll_reset", pll_reset, 1'b0);
      chk("midrst_md_opc", md_opc, 2'b00);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      chk("midrst_rsp_rdata", rsp_rdata, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      issue(2'b00, 8'h34, 8'h00, 8'h11, 1'b0, 5);

      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_mdrp_master.md
# pll_mdrp_master

Initiator for the Gowin PLLA dynamic-reconfiguration (MDRP) port: drives MDOPC/MDAINC/MDWDI, captures MDRDO, and optionally runs a PLL reset/relock sequence after reconfiguration. It sits between the command processor and the PLL wrapper's md* ports. Its clock is the same net fed to the wrapper's `mdclk`, so the block is fully synchronous to the MDRP port.

## Interface
- `RD_LAT`, 2: cycles from the read opcode cycle to the cycle in which `md_rdo` is sampled (1..7).
- `RST_CYCLES`, 16: `pll_reset` assertion length, in cycles (>=1).
- `LOCK_TIMEOUT`, 65535: maximum wait for lock, in cycles; 16-bit counter.

Ports:
- `clk` in 1: system clock, also drives the PLL `mdclk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 read, 01 write, 10 commit, 11 reserved.
- `cmd_addr` in 8: MDRP register address.
- `cmd_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 8: read data, valid with `rsp_valid`.
- `rsp_err` out 1: error flag, valid with `rsp_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `md_opc` out 2: to PLL MDOPC.
- `md_ainc` out 1: to PLL MDAINC; always 0 from this block.
- `md_wdi` out 8: to PLL MDWDI.
- `md_rdo` in 8: from PLL MDRDO.
- `pll_lock` in 1: PLL lock. Asynchronous; passed through a 2-FF synchronizer.
- `pll_reset` out 1: to PLL RESET, active-high.

## Operation
MDRP opcodes used by this block:
- 00: NOP.
- 11: load address from `md_wdi`.
- 01: write `md_wdi` to the current address.
- 10: read the current address.

All `md_*` outputs and `pll_reset` are registered.

States: IDLE, ADDR, WR, RD, RD_WAIT, RST, LOCK_WAIT, RESP.

Transitions:
- IDLE: on `cmd_valid & cmd_ready`, latch op/addr/wdata.
  - Read or write goes to ADDR.
  - Commit goes to RST.
  - Reserved goes to RESP with err=1.
- ADDR: `md_opc`=11, `md_wdi`=addr. Next state is WR (write) or RD (read).
- WR: `md_opc`=01, `md_wdi`=wdata. Next state is RESP.
- RD: `md_opc`=10. Next state is RD_WAIT; the wait counter loads `RD_LAT-1`.
- RD_WAIT: `md_opc`=00. Decrement the counter; at 0, sample `md_rdo` into `rsp_rdata` and go to RESP.
- RST: `pll_reset`=1 for `RST_CYCLES` cycles, then go to LOCK_WAIT with the timeout counter cleared.
- LOCK_WAIT: `pll_reset`=0.
  - Synchronized lock high goes to RESP with err=0.
  - Counter reaching `LOCK_TIMEOUT` goes to RESP with err=1.
- RESP: `rsp_valid`=1 for one cycle, then go to IDLE.

Output and ordering rules:
- `md_opc` is 00 in every state except ADDR, WR and RD.
- `md_wdi` holds its last value when not in use.
- `rsp_rdata` holds its last read value across writes and commits.
- Commands presented while busy are not accepted; `cmd_valid` may stay high.

## Timing
Reset values (all outputs): `md_opc`=00, `md_ainc`=0, `md_wdi`=0, `pll_reset`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `cmd_ready`=1. The state is IDLE and all counters are 0.

Latencies, counted from the accept edge (cycle 0) to the `rsp_valid` cycle:
- Write: ADDR at cycle 1, WR at cycle 2, `rsp_valid` at cycle 3.
- Read: ADDR at cycle 1, RD at cycle 2; `md_rdo` is sampled at cycle 2+`RD_LAT`, and `rsp_valid` follows one cycle after the sample.
- Commit: `pll_reset` high during cycles 1..`RST_CYCLES`. `rsp_valid` comes 1 cycle after the synchronized lock is seen, or 1 cycle after the timeout.

Back-to-back commands: the next accept can occur in the cycle after RESP, giving a minimum 1-cycle IDLE gap.

Boundary conditions:
- Lock already high when LOCK_WAIT is entered: the 2-FF synchronizer was cleared by `pll_reset`'s effect, so no shortcut is required. The block simply responds when the synchronized lock is high.
- Lock glitch: a single high sample of the synchronized lock is sufficient.
- Reset mid-operation: all outputs return to reset values immediately. This includes `pll_reset` dropping and `md_opc` returning to 00. No response is issued for the aborted command.
- `RD_LAT`=1: RD_WAIT lasts exactly one cycle.

## Configuration
Macro `PLL_MDRP_RESET_SEQ_EN`.
- Defined: commit performs the RST/LOCK_WAIT sequence. Write also auto-commits: WR is followed by RST instead of RESP.
- Undefined: the RST and LOCK_WAIT states and their counters are not built, and `pll_reset` is tied to 0. Commit behaves as reserved and returns err=1 at cycle 2. Writes respond at cycle 3.

## Test plan
- Write addr 0x12, data 0x5A (macro undefined) -> `md_opc`=11 with `md_wdi`=0x12 at cycle 1; `md_opc`=01 with `md_wdi`=0x5A at cycle 2; `rsp_valid`=1 and err=0 at cycle 3.
- Read addr 0x34, model returns 0xC3 at sampling cycle 4 (`RD_LAT`=2) -> `rsp_rdata`=0xC3, err=0, `rsp_valid` at cycle 5.
- Commit (macro defined, `RST_CYCLES`=16), model raises lock 40 cycles after reset falls -> `pll_reset` high for exactly 16 cycles; `rsp_valid` with err=0 about 43 cycles later.
- Commit with lock held low, `LOCK_TIMEOUT`=100 -> `rsp_err`=1 after 100 cycles in LOCK_WAIT.
- Reserved op 11 -> `rsp_valid`, err=1 at cycle 2; `md_opc` stays 00 throughout.
- Deassert `rst_n` during RST -> `pll_reset`=0, `busy`=0 and `cmd_ready`=1 immediately; no `rsp_valid` pulse.
